// File: rtl/mips_mem_pkg.sv
// Shared definitions for the M-stage data memory controller.
//   SIZE_B/SIZE_H/SIZE_W : memsizeM encodings (2'b11 is reserved and behaves as a word)
//   dmem_state_t         : controller FSM states
//   DEF_TIMEOUT_CYCLES   : default REQ-cycle limit before an access is aborted
package mips_mem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_t;
endpackage

// File: rtl/dmem_ctrl_load_ext.sv
// load_ext: picks the addressed byte/half out of a bus word and extends it.
//   word   in  32  raw bus read word
//   lane   in  2   byte address offset; lane[1] selects the half
//   size   in  2   access size (reserved encoding returns the full word)
//   sgn    in  1   1 = sign-extend, 0 = zero-extend
//   result out 32  extended load value
module load_ext
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] result
);
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    case (lane)
      2'd0:    byteSel = word[7:0];
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      default: byteSel = word[31:24];
    endcase
    halfSel = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  result = {{24{sgn & byteSel[7]}}, byteSel};
      SIZE_H:  result = {{16{sgn & halfSel[15]}}, halfSel};
      default: result = word;
    endcase
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: M-stage data access controller. Runs one req/ack bus transaction
// per aligned load/store, stalling the pipeline until it completes, and returns
// extended load data in readdataM.
//   clk, rst                      clock, synchronous active-high reset
//   memreadM/memwriteM/memsizeM/memsignedM/aluoutM/writedataM   M-stage access
//   readdataM                     registered extended load data
//   stallM, misalignM, buserrM    hazard-unit stall and one-cycle status flags
//   bus_req/we/addr/be/wdata      registered bus request, held through REQ
//   bus_ack/bus_rdata             one-cycle completion strobe and read word
// Optional feature macro: DMEM_TIMEOUT_EN -- aborts REQ after TIMEOUT_CYCLES
// cycles without ack and flags buserrM; without it REQ waits forever.
module dmem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [1:0]  memsizeM,
  input  logic        memsignedM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        buserrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("dmem_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  dmem_state_t state, stateNext;

  logic        access, aligned, start, timeout;
  logic [3:0]  beNext;
  logic [31:0] wdNext, loadData;
  logic [1:0]  laneQ, sizeQ;
  logic        sgnQ;

  assign access = memreadM | memwriteM;

  always_comb begin
    case (memsizeM)
      SIZE_B:  aligned = 1'b1;
      SIZE_H:  aligned = ~aluoutM[0];
      default: aligned = (aluoutM[1:0] == 2'b00);
    endcase
  end

  assign start = (state == ST_IDLE) && access && aligned;

  // Lane placement of the store: sub-word data is replicated so the
  // byte enables alone decide which lanes memory writes.
  always_comb begin
    case (memsizeM)
      SIZE_B: begin
        beNext = 4'b0001 << aluoutM[1:0];
        wdNext = {4{writedataM[7:0]}};
      end
      SIZE_H: begin
        beNext = aluoutM[1] ? 4'b1100 : 4'b0011;
        wdNext = {2{writedataM[15:0]}};
      end
      default: begin
        beNext = 4'b1111;
        wdNext = writedataM;
      end
    endcase
  end

  always_comb begin
    stateNext = state;
    stallM    = 1'b0;
    misalignM = 1'b0;
    bus_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          if (aligned) begin
            stateNext = ST_REQ;
            stallM    = 1'b1;
          end else begin
            misalignM = 1'b1;
          end
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        stallM  = 1'b1;
        if (bus_ack || timeout) stateNext = ST_DONE;
      end
      // DONE lets the pipeline advance; the inputs still describe the
      // finished instruction, so no new access may start here.
      default: stateNext = ST_IDLE;
    endcase
  end

  load_ext uLoadExt (
    .word   (bus_rdata),
    .lane   (laneQ),
    .size   (sizeQ),
    .sgn    (sgnQ),
    .result (loadData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
      laneQ     <= 2'd0;
      sizeQ     <= 2'd0;
      sgnQ      <= 1'b0;
      readdataM <= 32'h0;
    end else begin
      state <= stateNext;
      if (start) begin
        bus_we    <= memwriteM;
        bus_addr  <= {aluoutM[31:2], 2'b00};
        bus_be    <= beNext;
        bus_wdata <= wdNext;
        laneQ     <= aluoutM[1:0];
        sizeQ     <= memsizeM;
        sgnQ      <= memsignedM;
      end
      if (state == ST_REQ && bus_ack && !bus_we) readdataM <= loadData;
    end
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] toCnt;
  logic          errQ;

  // toCnt counts ack-less REQ cycles already spent; the cycle that would make
  // it reach TIMEOUT_CYCLES aborts. A same-cycle ack suppresses the abort.
  assign timeout = (state == ST_REQ) && !bus_ack && (toCnt == CW'(TIMEOUT_CYCLES - 1));
  assign buserrM = (state == ST_DONE) && errQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      toCnt <= '0;
      errQ  <= 1'b0;
    end else begin
      if (start)
        toCnt <= '0;
      else if (state == ST_REQ && !bus_ack)
        toCnt <= toCnt + 1'b1;
      if (state == ST_REQ) errQ <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign buserrM = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  import mips_mem_pkg::*;

`ifdef DMEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memreadM = 1'b0, memwriteM = 1'b0, memsignedM = 1'b0;
  logic [1:0]  memsizeM = 2'b00;
  logic [31:0] aluoutM = 32'h0, writedataM = 32'h0;
  logic [31:0] readdataM;
  logic        stallM, misalignM, buserrM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  dmem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .memreadM(memreadM), .memwriteM(memwriteM), .memsizeM(memsizeM),
    .memsignedM(memsignedM), .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM), .misalignM(misalignM), .buserrM(buserrM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } done_t;

  req_t        reqQ[$];
  done_t       doneQ[$];
  logic [31:0] misQ[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic missing(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT event with no expected entry", name);
  endtask

  // Monitor: compares bus requests, completions and misalign flags against
  // the expectation queues filled by the stimulus.
  logic prevReq = 1'b0;
  req_t cur;
  always @(negedge clk) begin
    if (rst) begin
      prevReq = 1'b0;
    end else begin
      if (bus_req && !prevReq) begin
        if (reqQ.size() == 0) missing("unexpected_req");
        else begin
          cur = reqQ.pop_front();
          chk("req_we", bus_we, cur.we);
          chk("req_addr", bus_addr, cur.addr);
          chk("req_be", bus_be, cur.be);
          chk("req_wdata", bus_wdata, cur.wdata);
        end
      end else if (bus_req) begin
        chk("req_stable_addr", bus_addr, cur.addr);
        chk("req_stable_be", bus_be, cur.be);
        chk("req_stable_wdata", bus_wdata, cur.wdata);
      end
      if (!bus_req && prevReq) begin
        if (doneQ.size() == 0) missing("unexpected_done");
        else begin
          done_t d;
          d = doneQ.pop_front();
          chk("done_readdata", readdataM, d.rd);
          chk("done_buserr", buserrM, d.err);
        end
      end
      if (misalignM) begin
        if (misQ.size() == 0) missing("unexpected_misalign");
        else chk("misalign_addr", aluoutM, misQ.pop_front());
      end
      prevReq = bus_req;
    end
  end

  task automatic clearIn();
    memreadM = 1'b0; memwriteM = 1'b0; memsizeM = 2'b00; memsignedM = 1'b0;
    aluoutM = 32'h0; writedataM = 32'h0;
  endtask

  // One aligned access; ack arrives in REQ cycle number `delay` (0 = first).
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int delay, input logic [3:0] expBe, input logic [31:0] expWd,
                        input logic [31:0] expRd);
    req_t r;
    done_t d;
    @(posedge clk); #1;
    memreadM = rd; memwriteM = wr; memsizeM = sz; memsignedM = sgn;
    aluoutM = addr; writedataM = wd;
    r.we = wr; r.addr = {addr[31:2], 2'b00}; r.be = expBe; r.wdata = expWd;
    reqQ.push_back(r);
    d.rd = expRd; d.err = 1'b0;
    doneQ.push_back(d);
    @(negedge clk); chk("stall_detect", stallM, 1);
    for (int i = 0; i <= delay; i++) begin
      @(posedge clk); #1;
      if (i == delay) begin bus_ack = 1'b1; bus_rdata = rdata; end
      @(negedge clk); chk("stall_req", stallM, 1);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk); chk("stall_done", stallM, 0);
    @(posedge clk); #1;
    clearIn();
  endtask

  task automatic misaligned(input logic wr, input logic [1:0] sz, input logic [31:0] addr);
    @(posedge clk); #1;
    memreadM = ~wr; memwriteM = wr; memsizeM = sz; aluoutM = addr;
    misQ.push_back(addr);
    @(negedge clk);
    chk("mis_flag", misalignM, 1);
    chk("mis_stall", stallM, 0);
    chk("mis_req", bus_req, 0);
    @(posedge clk); #1;
    clearIn();
    @(negedge clk);
    chk("mis_one_cycle", misalignM, 0);
    chk("mis_req_after", bus_req, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_readdata", readdataM, 0);
    chk("rst_stall", stallM, 0);
    chk("rst_misalign", misalignM, 0);
    chk("rst_buserr", buserrM, 0);
    #1 rst = 1'b0;

    //     rd    wr    size    sgn   addr          wdata         rdata         dly be       expWd         expRd
    access(1'b0, 1'b1, SIZE_W, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000);
    access(1'b1, 1'b0, SIZE_B, 1'b1, 32'h0000_0203, 32'h0,         32'h80FF_0000, 0, 4'b1000, 32'h0,         32'hFFFF_FF80);
    access(1'b1, 1'b0, SIZE_B, 1'b0, 32'h0000_0203, 32'h0,         32'h80FF_0000, 1, 4'b1000, 32'h0,         32'h0000_0080);
    access(1'b0, 1'b1, SIZE_H, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 32'h0,        0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
    access(1'b1, 1'b0, SIZE_H, 1'b1, 32'h0000_0002, 32'h0,         32'h8001_1234, 0, 4'b1100, 32'h0,         32'hFFFF_8001);
    access(1'b1, 1'b0, SIZE_H, 1'b0, 32'h0000_0000, 32'h0,         32'h8001_1234, 0, 4'b0011, 32'h0,         32'h0000_1234);
    access(1'b0, 1'b1, SIZE_B, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0,        0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_1234);
    access(1'b1, 1'b0, SIZE_W, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 2, 4'b1111, 32'h0,         32'hCAFE_F00D);
    access(1'b0, 1'b1, 2'b11,  1'b0, 32'h0000_0020, 32'h1357_9BDF, 32'h0,        0, 4'b1111, 32'h1357_9BDF, 32'hCAFE_F00D);
    access(1'b1, 1'b0, SIZE_B, 1'b1, 32'h0000_0001, 32'h0,         32'h0000_7F00, 0, 4'b0010, 32'h0,         32'h0000_007F);

    misaligned(1'b0, SIZE_W, 32'h0000_0006);
    misaligned(1'b1, SIZE_H, 32'h0000_0003);

`ifdef DMEM_TIMEOUT_EN
    begin
      req_t r;
      done_t d;
      @(posedge clk); #1;
      memreadM = 1'b1; memsizeM = SIZE_W; aluoutM = 32'h0000_0080;
      r.we = 1'b0; r.addr = 32'h0000_0080; r.be = 4'b1111; r.wdata = 32'h0;
      reqQ.push_back(r);
      d.rd = 32'h0000_007F; d.err = 1'b1;
      doneQ.push_back(d);
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        @(negedge clk); chk("to_req_cycle", bus_req, 1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("to_buserr", buserrM, 1);
      chk("to_stall_done", stallM, 0);
      @(posedge clk); #1;
      clearIn();
      @(negedge clk);
      chk("to_buserr_pulse", buserrM, 0);
      chk("to_idle_req", bus_req, 0);
    end
`endif

    // Reset in the third REQ cycle, then a stray ack.
    begin
      req_t r;
      @(posedge clk); #1;
      memreadM = 1'b1; memsizeM = SIZE_W; aluoutM = 32'h0000_0040;
      r.we = 1'b0; r.addr = 32'h0000_0040; r.be = 4'b1111; r.wdata = 32'h0;
      reqQ.push_back(r);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clearIn();
      @(negedge clk);
      chk("rstreq_bus_req", bus_req, 0);
      chk("rstreq_readdata", readdataM, 0);
      chk("rstreq_stall", stallM, 0);
      @(posedge clk); #1;
      bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = 32'h0;
      @(negedge clk);
      chk("late_ack_req", bus_req, 0);
      chk("late_ack_readdata", readdataM, 0);
      chk("late_ack_stall", stallM, 0);
    end

    repeat (2) @(posedge clk);
    chk("reqQ_drained", reqQ.size(), 0);
    chk("doneQ_drained", doneQ.size(), 0);
    chk("misQ_drained", misQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
